// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit path.
// Contents: element slot codes, mark/gap lengths in Morse units, and the
// transmitter FSM state type.
package morse_pkg;

    // 2-bit element slot codes; a pattern holds 5 slots, first in [9:8].
    localparam logic [1:0] ELEM_END  = 2'b00;
    localparam logic [1:0] ELEM_DOT  = 2'b01;
    localparam logic [1:0] ELEM_DASH = 2'b10;

    // Phase lengths in Morse time units.
    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 4;  // plus the preceding 3-unit char gap = 7

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

endpackage

// File: rtl/morse_char_rom.sv
// Combinational ASCII -> Morse element pattern lookup.
// Ports:
//   ascii     in  8   character code
//   supported out 1   character can be sent (letter, digit or space)
//   is_space  out 1   character is a space (word gap, no keying)
//   pattern   out 10  5 slots of 2 bits, first element in [9:8]
// Lowercase letters map to the same code as uppercase.
module morse_char_rom
    import morse_pkg::*;
(
    input  logic [7:0] ascii,
    output logic       supported,
    output logic       is_space,
    output logic [9:0] pattern
);

    logic [7:0] upper;

    always_comb begin
        // Fold a-z onto A-Z so one table serves both cases.
        if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            upper = ascii - 8'h20;
        end else begin
            upper = ascii;
        end
    end

    always_comb begin
        supported = 1'b1;
        is_space  = 1'b0;
        pattern   = 10'b00_00_00_00_00;
        case (upper)
            8'h20: is_space = 1'b1;
            8'h41: pattern = 10'b01_10_00_00_00; // A .-
            8'h42: pattern = 10'b10_01_01_01_00; // B -...
            8'h43: pattern = 10'b10_01_10_01_00; // C -.-.
            8'h44: pattern = 10'b10_01_01_00_00; // D -..
            8'h45: pattern = 10'b01_00_00_00_00; // E .
            8'h46: pattern = 10'b01_01_10_01_00; // F ..-.
            8'h47: pattern = 10'b10_10_01_00_00; // G --.
            8'h48: pattern = 10'b01_01_01_01_00; // H ....
            8'h49: pattern = 10'b01_01_00_00_00; // I ..
            8'h4A: pattern = 10'b01_10_10_10_00; // J .---
            8'h4B: pattern = 10'b10_01_10_00_00; // K -.-
            8'h4C: pattern = 10'b01_10_01_01_00; // L .-..
            8'h4D: pattern = 10'b10_10_00_00_00; // M --
            8'h4E: pattern = 10'b10_01_00_00_00; // N -.
            8'h4F: pattern = 10'b10_10_10_00_00; // O ---
            8'h50: pattern = 10'b01_10_10_01_00; // P .--.
            8'h51: pattern = 10'b10_10_01_10_00; // Q --.-
            8'h52: pattern = 10'b01_10_01_00_00; // R .-.
            8'h53: pattern = 10'b01_01_01_00_00; // S ...
            8'h54: pattern = 10'b10_00_00_00_00; // T -
            8'h55: pattern = 10'b01_01_10_00_00; // U ..-
            8'h56: pattern = 10'b01_01_01_10_00; // V ...-
            8'h57: pattern = 10'b01_10_10_00_00; // W .--
            8'h58: pattern = 10'b10_01_01_10_00; // X -..-
            8'h59: pattern = 10'b10_01_10_10_00; // Y -.--
            8'h5A: pattern = 10'b10_10_01_01_00; // Z --..
            8'h30: pattern = 10'b10_10_10_10_10; // 0 -----
            8'h31: pattern = 10'b01_10_10_10_10; // 1 .----
            8'h32: pattern = 10'b01_01_10_10_10; // 2 ..---
            8'h33: pattern = 10'b01_01_01_10_10; // 3 ...--
            8'h34: pattern = 10'b01_01_01_01_10; // 4 ....-
            8'h35: pattern = 10'b01_01_01_01_01; // 5 .....
            8'h36: pattern = 10'b10_01_01_01_01; // 6 -....
            8'h37: pattern = 10'b10_10_01_01_01; // 7 --...
            8'h38: pattern = 10'b10_10_10_01_01; // 8 ---..
            8'h39: pattern = 10'b10_10_10_10_01; // 9 ----.
            default: supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_code_transmitter.sv
// Character-to-Morse keyer.
// Accepts one ASCII character per valid/ready handshake and produces the
// timed keying waveform on Key (1 = tone on).
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse time unit (>= 1)
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   CharIn[7:0]           character; CharValid qualifies it
//   CharReady             high in IDLE; a character is taken when both are high
//   Key                   registered keying output
//   Busy                  a character is in progress
//   Error                 one-cycle pulse when an unsupported character is dropped
//   Dot, Dash, Space, EndSeq
//                         loopback pulses, only when MORSE_TX_LOOPBACK_EN is
//                         defined; tied to 0 otherwise
module morse_code_transmitter
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] CharIn,
    input  logic       CharValid,
    output logic       CharReady,
    output logic       Key,
    output logic       Busy,
    output logic       Error,
    output logic       Dot,
    output logic       Dash,
    output logic       Space,
    output logic       EndSeq
);

    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    typedef logic [CW-1:0] cnt_t;

    // Counter preload for a phase lasting 'units' Morse units.
    function automatic cnt_t phase_len(input int units);
        return cnt_t'(units * UNIT_CYCLES - 1);
    endfunction

    function automatic cnt_t mark_len(input logic [1:0] elem);
        return (elem == ELEM_DASH) ? phase_len(DASH_UNITS) : phase_len(DOT_UNITS);
    endfunction

    state_t     state_reg, state_next;
    cnt_t       cnt_reg, cnt_next;
    logic [9:0] slots_reg, slots_next;
    logic [7:0] char_reg, char_next;
    logic       key_reg, key_next;
    logic       drop;

    logic       rom_supported;
    logic       rom_is_space;
    logic [9:0] rom_pattern;

    morse_char_rom u_rom (
        .ascii     (char_reg),
        .supported (rom_supported),
        .is_space  (rom_is_space),
        .pattern   (rom_pattern)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            slots_reg <= '0;
            char_reg  <= '0;
            key_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            slots_reg <= slots_next;
            char_reg  <= char_next;
            key_reg   <= key_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        slots_next = slots_reg;
        char_next  = char_reg;
        key_next   = key_reg;
        drop       = 1'b0;
        case (state_reg)
            IDLE: begin
                key_next = 1'b0;
                if (CharValid) begin
                    char_next  = CharIn;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (!rom_supported) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end else if (rom_is_space) begin
                    cnt_next   = phase_len(WORD_GAP_UNITS);
                    state_next = WORD_GAP;
                end else begin
                    slots_next = rom_pattern;
                    cnt_next   = mark_len(rom_pattern[9:8]);
                    key_next   = 1'b1;
                    state_next = MARK;
                end
            end
            MARK: begin
                if (cnt_reg == '0) begin
                    // Retire the element just sent; the next one moves to [9:8].
                    slots_next = {slots_reg[7:0], ELEM_END};
                    key_next   = 1'b0;
                    if (slots_reg[7:6] != ELEM_END) begin
                        cnt_next   = phase_len(ELEM_GAP_UNITS);
                        state_next = ELEM_GAP;
                    end else begin
                        cnt_next   = phase_len(CHAR_GAP_UNITS);
                        state_next = CHAR_GAP;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ELEM_GAP: begin
                if (cnt_reg == '0) begin
                    cnt_next   = mark_len(slots_reg[9:8]);
                    key_next   = 1'b1;
                    state_next = MARK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                key_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign CharReady = (state_reg == IDLE);
    assign Busy      = (state_reg != IDLE);
    assign Key       = key_reg;
    assign Error     = drop;

`ifdef MORSE_TX_LOOPBACK_EN
    logic dot_reg, dash_reg, space_reg, endseq_reg;
    logic enter_mark, enter_char_gap, enter_word_gap;

    // Pulses are registered alongside Key, so each one lines up with the
    // first cycle of the phase it marks.
    assign enter_mark     = (state_next == MARK)     && (state_reg != MARK);
    assign enter_char_gap = (state_next == CHAR_GAP) && (state_reg != CHAR_GAP);
    assign enter_word_gap = (state_next == WORD_GAP) && (state_reg != WORD_GAP);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dot_reg    <= 1'b0;
            dash_reg   <= 1'b0;
            space_reg  <= 1'b0;
            endseq_reg <= 1'b0;
        end else begin
            dot_reg    <= enter_mark && (slots_next[9:8] == ELEM_DOT);
            dash_reg   <= enter_mark && (slots_next[9:8] == ELEM_DASH);
            space_reg  <= enter_word_gap;
            endseq_reg <= enter_char_gap;
        end
    end

    assign Dot    = dot_reg;
    assign Dash   = dash_reg;
    assign Space  = space_reg;
    assign EndSeq = endseq_reg;
`else
    assign Dot    = 1'b0;
    assign Dash   = 1'b0;
    assign Space  = 1'b0;
    assign EndSeq = 1'b0;
`endif

endmodule
